// File: rtl/bank_htu_way_alloc.sv
// Way allocation and tag lookup for one 8-way HTU bank: hit/miss resolution,
// victim selection (invalid first, else PLRU oldest), dirty write-back and PLRU access pulses.
module bank_htu_way_alloc #(
  parameter int TAG_W = 20
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             req_valid_i,
  output logic             req_ready_o,
  input  logic [TAG_W-1:0] req_tag_i,
  input  logic             req_write_i,
  output logic             resp_valid_o,
  input  logic             resp_ready_i,
  output logic             resp_hit_o,
  output logic [7:0]       resp_way_o,
  output logic             evict_valid_o,
  input  logic             evict_ready_i,
  output logic [TAG_W-1:0] evict_tag_o,
  output logic [7:0]       evict_way_o,
  output logic             plru_access_valid_o,
  output logic [7:0]       plru_access_array_o,
  input  logic [7:0]       plru_oldest_way_i
);

  typedef enum logic [2:0] {IDLE, LOOKUP, EVICT, FILL, RESP} state_t;

  state_t           state_reg, state_next;
  logic [TAG_W-1:0] tag_mem [8];
  logic [7:0]       valid_reg, dirty_reg;
  logic [TAG_W-1:0] req_tag_reg;
  logic             req_write_reg;
  logic [2:0]       victim_reg;
  logic             resp_hit_reg;
  logic [7:0]       resp_way_reg;

  logic [7:0] match;
  logic [2:0] hit_idx, inv_idx, old_idx, victim_idx;
  logic       any_hit;

  for (genvar gi = 0; gi < 8; gi++) begin : g_match
    assign match[gi] = valid_reg[gi] && (tag_mem[gi] == req_tag_reg);
  end

  // Priority encoders: lowest index wins in every case; all-zero inputs resolve to way 0.
  always_comb begin
    hit_idx = '0;
    inv_idx = '0;
    old_idx = '0;
    for (int i = 7; i >= 0; i--) begin
      if (match[i]) hit_idx = 3'(i);
      if (!valid_reg[i]) inv_idx = 3'(i);
      if (plru_oldest_way_i[i]) old_idx = 3'(i);
    end
  end

  assign any_hit    = |match;
  assign victim_idx = (&valid_reg) ? old_idx : inv_idx;

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (req_valid_i) state_next = LOOKUP;
      LOOKUP: begin
        if (any_hit) state_next = RESP;
        else if (valid_reg[victim_idx] && dirty_reg[victim_idx]) state_next = EVICT;
        else state_next = FILL;
      end
      EVICT:   if (evict_ready_i) state_next = FILL;
      FILL:    state_next = RESP;
      RESP:    if (resp_ready_i) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_reg     <= IDLE;
      valid_reg     <= '0;
      dirty_reg     <= '0;
      req_tag_reg   <= '0;
      req_write_reg <= 1'b0;
      victim_reg    <= '0;
      resp_hit_reg  <= 1'b0;
      resp_way_reg  <= '0;
    end else begin
      state_reg <= state_next;
      case (state_reg)
        IDLE: begin
          if (req_valid_i) begin
            req_tag_reg   <= req_tag_i;
            req_write_reg <= req_write_i;
          end
        end
        LOOKUP: begin
          if (any_hit) begin
            if (req_write_reg) dirty_reg[hit_idx] <= 1'b1;
            resp_hit_reg <= 1'b1;
            resp_way_reg <= 8'(1) << hit_idx;
          end else begin
            victim_reg <= victim_idx;
          end
        end
        FILL: begin
          valid_reg[victim_reg] <= 1'b1;
          dirty_reg[victim_reg] <= req_write_reg;
          resp_hit_reg          <= 1'b0;
          resp_way_reg          <= 8'(1) << victim_reg;
        end
        default: ;
      endcase
    end
  end

  // Tags are don't-care after reset, so the array carries no reset.
  always_ff @(posedge clk_i) begin
    if (rst_ni && state_reg == FILL) tag_mem[victim_reg] <= req_tag_reg;
  end

  always_comb begin
    req_ready_o         = 1'b0;
    resp_valid_o        = 1'b0;
    resp_hit_o          = 1'b0;
    resp_way_o          = '0;
    evict_valid_o       = 1'b0;
    evict_tag_o         = '0;
    evict_way_o         = '0;
    plru_access_valid_o = 1'b0;
    plru_access_array_o = '0;
    if (rst_ni) begin
      case (state_reg)
        IDLE: req_ready_o = 1'b1;
        LOOKUP: begin
          if (any_hit) begin
            plru_access_valid_o = 1'b1;
            plru_access_array_o = 8'(1) << hit_idx;
          end
        end
        EVICT: begin
          evict_valid_o = 1'b1;
          evict_tag_o   = tag_mem[victim_reg];
          evict_way_o   = 8'(1) << victim_reg;
        end
        FILL: begin
          plru_access_valid_o = 1'b1;
          plru_access_array_o = 8'(1) << victim_reg;
        end
        RESP: begin
          resp_valid_o = 1'b1;
          resp_hit_o   = resp_hit_reg;
          resp_way_o   = resp_way_reg;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_bank_htu_way_alloc.sv
// Self-checking bench for bank_htu_way_alloc: directed scenarios plus random traffic
// compared cycle by cycle against an array-based cache model.
module tb_bank_htu_way_alloc;
  localparam int TAG_W = 20;

  logic             clk_i = 1'b0;
  logic             rst_ni = 1'b0;
  logic             req_valid_i = 1'b0;
  logic             req_ready_o;
  logic [TAG_W-1:0] req_tag_i = '0;
  logic             req_write_i = 1'b0;
  logic             resp_valid_o;
  logic             resp_ready_i = 1'b0;
  logic             resp_hit_o;
  logic [7:0]       resp_way_o;
  logic             evict_valid_o;
  logic             evict_ready_i = 1'b0;
  logic [TAG_W-1:0] evict_tag_o;
  logic [7:0]       evict_way_o;
  logic             plru_access_valid_o;
  logic [7:0]       plru_access_array_o;
  logic [7:0]       plru_oldest_way_i = '0;

  int vectors = 0;
  int miscompares = 0;

  logic [TAG_W-1:0] m_tag [8];
  bit               m_valid [8];
  bit               m_dirty [8];

  always #5 clk_i = ~clk_i;

  bank_htu_way_alloc #(.TAG_W(TAG_W)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
    .req_tag_i(req_tag_i), .req_write_i(req_write_i),
    .resp_valid_o(resp_valid_o), .resp_ready_i(resp_ready_i),
    .resp_hit_o(resp_hit_o), .resp_way_o(resp_way_o),
    .evict_valid_o(evict_valid_o), .evict_ready_i(evict_ready_i),
    .evict_tag_o(evict_tag_o), .evict_way_o(evict_way_o),
    .plru_access_valid_o(plru_access_valid_o), .plru_access_array_o(plru_access_array_o),
    .plru_oldest_way_i(plru_oldest_way_i)
  );

  task automatic model_clear();
    for (int i = 0; i < 8; i++) begin
      m_valid[i] = 0;
      m_dirty[i] = 0;
    end
  endtask

  task automatic test_reset();
    rst_ni = 1'b0;
    repeat (2) @(negedge clk_i);
    vectors++;
    if ({req_ready_o, resp_valid_o, resp_hit_o, resp_way_o, evict_valid_o, evict_tag_o,
         evict_way_o, plru_access_valid_o, plru_access_array_o} !== '0) begin
      miscompares++;
      $display("FAIL reset_outputs: ready=%b resp_v=%b evict_v=%b plru_v=%b, required all 0",
               req_ready_o, resp_valid_o, evict_valid_o, plru_access_valid_o);
    end
    rst_ni = 1'b1;
    @(negedge clk_i);
    vectors++;
    if (req_ready_o !== 1'b1 || {resp_valid_o, evict_valid_o, plru_access_valid_o} !== 3'b000) begin
      miscompares++;
      $display("FAIL after_reset: ready=%b resp_v=%b evict_v=%b plru_v=%b, required ready=1 others 0",
               req_ready_o, resp_valid_o, evict_valid_o, plru_access_valid_o);
    end
    model_clear();
  endtask

  // One complete request, checked each cycle. Entered and left at a negedge in IDLE.
  task automatic do_req(input logic [TAG_W-1:0] t, input bit w, input logic [7:0] oldest,
                        input int ev_wait, input int rs_wait, input bit hold_req);
    int hit, v;
    bit ev;
    logic [7:0] exp_way;
    logic [TAG_W-1:0] ev_tag;
    hit = -1;
    v = -1;
    for (int i = 0; i < 8; i++) if (hit < 0 && m_valid[i] && m_tag[i] == t) hit = i;
    if (hit < 0) begin
      for (int i = 0; i < 8; i++) if (v < 0 && !m_valid[i]) v = i;
      if (v < 0) begin
        v = 0;
        for (int i = 7; i >= 0; i--) if (oldest[i]) v = i;
      end
    end
    ev = (hit < 0) && m_valid[v] && m_dirty[v];
    ev_tag = (hit < 0) ? m_tag[v] : '0;
    exp_way = 8'b1 << ((hit >= 0) ? hit : v);

    // cycle 0: handshake
    req_valid_i = 1'b1; req_tag_i = t; req_write_i = w; plru_oldest_way_i = oldest;
    vectors++;
    if (req_ready_o !== 1'b1) begin
      miscompares++; $display("FAIL req_ready: got %b, required 1", req_ready_o);
    end
    @(negedge clk_i);
    if (!hold_req) req_valid_i = 1'b0;
    // cycle 1: LOOKUP
    vectors++;
    if (plru_access_valid_o !== (hit >= 0) ||
        plru_access_array_o !== ((hit >= 0) ? exp_way : 8'h00) || resp_valid_o !== 1'b0) begin
      miscompares++;
      $display("FAIL lookup_plru: valid=%b array=%h resp_v=%b, required valid=%b array=%h resp_v=0",
               plru_access_valid_o, plru_access_array_o, resp_valid_o, hit >= 0,
               (hit >= 0) ? exp_way : 8'h00);
    end
    @(negedge clk_i);
    if (hit < 0) begin
      if (ev) begin
        for (int c = 0; c <= ev_wait; c++) begin
          if (c == ev_wait) evict_ready_i = 1'b1;
          vectors++;
          if (evict_valid_o !== 1'b1 || evict_tag_o !== ev_tag || evict_way_o !== exp_way ||
              plru_access_valid_o !== 1'b0 || resp_valid_o !== 1'b0) begin
            miscompares++;
            $display("FAIL evict: valid=%b tag=%h way=%h, required valid=1 tag=%h way=%h",
                     evict_valid_o, evict_tag_o, evict_way_o, ev_tag, exp_way);
          end
          @(negedge clk_i);
        end
        evict_ready_i = 1'b0;
      end
      // FILL cycle
      vectors++;
      if (plru_access_valid_o !== 1'b1 || plru_access_array_o !== exp_way ||
          evict_valid_o !== 1'b0 || resp_valid_o !== 1'b0) begin
        miscompares++;
        $display("FAIL fill: plru_v=%b array=%h evict_v=%b resp_v=%b, required plru_v=1 array=%h evict_v=0 resp_v=0",
                 plru_access_valid_o, plru_access_array_o, evict_valid_o, resp_valid_o, exp_way);
      end
      @(negedge clk_i);
    end
    // RESP cycles
    for (int c = 0; c <= rs_wait; c++) begin
      if (c == rs_wait) resp_ready_i = 1'b1;
      vectors++;
      if (resp_valid_o !== 1'b1 || resp_hit_o !== (hit >= 0) || resp_way_o !== exp_way ||
          req_ready_o !== 1'b0 || plru_access_valid_o !== 1'b0 || evict_valid_o !== 1'b0) begin
        miscompares++;
        $display("FAIL resp: valid=%b hit=%b way=%h ready=%b, required valid=1 hit=%b way=%h ready=0",
                 resp_valid_o, resp_hit_o, resp_way_o, req_ready_o, hit >= 0, exp_way);
      end
      @(negedge clk_i);
    end
    resp_ready_i = 1'b0;
    req_valid_i = 1'b0;

    if (hit >= 0) begin
      if (w) m_dirty[hit] = 1;
    end else begin
      m_tag[v] = t; m_valid[v] = 1; m_dirty[v] = w;
    end
    $display("req tag=%h wr=%0d oldest=%h -> %s way=%h evict=%0d", t, w, oldest,
             (hit >= 0) ? "hit" : "miss", exp_way, ev);
  endtask

  task automatic test_first_miss();
    do_req(20'h00001, 0, 8'h00, 0, 0, 0);
  endtask

  task automatic test_fill_and_hit();
    for (int i = 2; i <= 8; i++) do_req(TAG_W'(i), 0, 8'h00, 0, 0, 0);
    do_req(20'h3, 0, 8'h01, 0, 0, 0);
  endtask

  task automatic test_dirty_evict();
    do_req(20'h5, 1, 8'h01, 0, 0, 0);
    do_req(20'hA, 0, 8'h10, 3, 0, 0);
    do_req(20'h5, 0, 8'h01, 0, 0, 0);
  endtask

  task automatic test_clean_victim();
    do_req(20'h9, 0, 8'h10, 0, 0, 0);
  endtask

  task automatic test_resp_backpressure();
    do_req(20'h9, 0, 8'h02, 0, 4, 1);
    do_req(20'h2, 0, 8'h02, 0, 0, 0);
  endtask

  task automatic test_reset_mid_evict();
    do_req(20'h9, 1, 8'h02, 0, 0, 0);
    req_valid_i = 1'b1; req_tag_i = 20'h77; req_write_i = 1'b0; plru_oldest_way_i = 8'h10;
    @(negedge clk_i);
    req_valid_i = 1'b0;
    @(negedge clk_i);
    vectors++;
    if (evict_valid_o !== 1'b1) begin
      miscompares++; $display("FAIL mid_evict_setup: evict_valid=%b, required 1", evict_valid_o);
    end
    rst_ni = 1'b0;
    @(negedge clk_i);
    rst_ni = 1'b1;
    vectors++;
    if (evict_valid_o !== 1'b0 || req_ready_o !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_in_evict: evict_valid=%b ready=%b, required 0 0", evict_valid_o, req_ready_o);
    end
    @(negedge clk_i);
    vectors++;
    if (evict_valid_o !== 1'b0 || req_ready_o !== 1'b1) begin
      miscompares++;
      $display("FAIL after_reset_evict: evict_valid=%b ready=%b, required 0 1", evict_valid_o, req_ready_o);
    end
    model_clear();
    do_req(20'h9, 0, 8'h10, 0, 0, 0);
  endtask

  task automatic test_random();
    for (int n = 0; n < 60; n++) begin
      logic [7:0] old;
      old = ($urandom_range(0, 4) == 0) ? 8'h00 : 8'($urandom);
      do_req(TAG_W'($urandom_range(1, 14)), bit'($urandom_range(0, 1)), old,
             $urandom_range(0, 2), $urandom_range(0, 2), bit'($urandom_range(0, 1)));
    end
  endtask

  initial begin
    test_reset();
    test_first_miss();
    test_fill_and_hit();
    test_dirty_evict();
    test_clean_victim();
    test_resp_backpressure();
    test_reset_mid_evict();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
